// File: rtl/uart_tx_frame.sv
// Double-buffered UART transmitter: 1 start, 8 data bits LSB first, optional parity, 1-2 stop bits.
// A byte can be queued in the holding register while the shifter sends, so frames leave back-to-back.
module uart_tx_frame #(
  parameter int C_CLK_FRQ   = 100000000,
  parameter int C_TRX_RATE  = 1000000,
  parameter int C_PARITY    = 0,
  parameter int C_STOP_BITS = 1
) (
  input  logic       clock,
  input  logic       rstb,
  input  logic       send,
  input  logic [7:0] data,
  output logic       busy,
  output logic       idle,
  output logic       error,
  output logic       tx
);

  localparam int C_PERIOD = C_CLK_FRQ / C_TRX_RATE;
  localparam int CNT_W    = $clog2(C_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_PERIOD - 1);
  localparam logic HAS_PARITY = (C_PARITY != 0);
  localparam logic ODD_PARITY = (C_PARITY == 1);
  localparam logic TWO_STOP   = (C_STOP_BITS == 2);

  typedef enum logic [2:0] {sIDLE, sSTART, sDATA, sPARITY, sSTOP} state_t;

  state_t           state_q;
  logic [7:0]       hold_q;
  logic             hold_full_q;
  logic [7:0]       shift_q;
  logic             parity_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic             stop_q;
  logic             tx_q;
  logic             idle_q;
  logic             error_q;

  logic       bit_end;
  logic       frame_end;
  logic       load;
  logic       accept;
  logic       hold_full_d;
  logic [7:0] hold_d;

  assign bit_end   = (cnt_q == CNT_LAST);
  assign frame_end = (state_q == sSTOP) && bit_end && (!TWO_STOP || stop_q);
  assign load      = hold_full_q && ((state_q == sIDLE) || frame_end);
  // The slot freed by a load is refilled on the same edge, so that send is not an overrun.
  assign accept      = send && (!hold_full_q || load);
  assign hold_full_d = accept ? 1'b1 : (load ? 1'b0 : hold_full_q);
  assign hold_d      = accept ? data : hold_q;

  always_ff @(posedge clock) begin
    if (!rstb) begin
      state_q     <= sIDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      cnt_q       <= '0;
      bit_q       <= '0;
      stop_q      <= 1'b0;
      tx_q        <= 1'b1;
      idle_q      <= 1'b1;
      error_q     <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      error_q     <= send && !accept;
      idle_q      <= 1'b0;
      if (load) begin
        state_q  <= sSTART;
        shift_q  <= hold_q;
        parity_q <= ODD_PARITY ? ~(^hold_q) : (^hold_q);
        cnt_q    <= '0;
        bit_q    <= '0;
        stop_q   <= 1'b0;
        tx_q     <= 1'b0;
      end else begin
        case (state_q)
          sIDLE: begin
            tx_q   <= 1'b1;
            idle_q <= !hold_full_d;
          end
          sSTART: begin
            if (bit_end) begin
              cnt_q   <= '0;
              state_q <= sDATA;
              tx_q    <= shift_q[0];
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          sDATA: begin
            if (bit_end) begin
              cnt_q <= '0;
              if (bit_q == 3'd7) begin
                if (HAS_PARITY) begin
                  state_q <= sPARITY;
                  tx_q    <= parity_q;
                end else begin
                  state_q <= sSTOP;
                  tx_q    <= 1'b1;
                end
              end else begin
                bit_q   <= bit_q + 3'd1;
                shift_q <= shift_q >> 1;
                tx_q    <= shift_q[1];
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          sPARITY: begin
            if (bit_end) begin
              cnt_q   <= '0;
              state_q <= sSTOP;
              tx_q    <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          sSTOP: begin
            if (bit_end) begin
              cnt_q  <= '0;
              stop_q <= ~stop_q;
              if (frame_end) begin
                state_q <= sIDLE;
                tx_q    <= 1'b1;
                idle_q  <= !hold_full_d;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: begin
            state_q <= sIDLE;
            tx_q    <= 1'b1;
          end
        endcase
      end
    end
  end

  assign busy  = hold_full_q;
  assign idle  = idle_q;
  assign error = error_q;
  assign tx    = tx_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four configurations (plain, even, odd, two stop bits) at 10 clocks per bit,
// checked against a bit-level line model and a mid-bit sampling receiver.
module tb_uart_tx_frame;

  localparam int P = 10;

  logic       clock;
  logic [3:0] rstb_v;
  logic [3:0] send_v;
  logic [7:0] data_v [4];
  wire  [3:0] busy_v;
  wire  [3:0] idle_v;
  wire  [3:0] error_v;
  wire  [3:0] tx_v;

  int n_checks = 0;
  int n_pass   = 0;

  int         sl_q[$];
  logic [7:0] sd_q[$];
  logic [7:0] hs_q[$];
  int         rst_slot;
  logic       rec_tx[$];
  logic       rec_err[$];
  logic       rec_busy[$];
  logic       rec_idle[$];
  logic       exp_tx[$];
  logic [7:0] exp_b_q[$];
  logic [7:0] dec_q[$];
  int         ferr;

  uart_tx_frame #(.C_CLK_FRQ(100000000), .C_TRX_RATE(10000000), .C_PARITY(0), .C_STOP_BITS(1)) u_plain (
    .clock(clock), .rstb(rstb_v[0]), .send(send_v[0]), .data(data_v[0]),
    .busy(busy_v[0]), .idle(idle_v[0]), .error(error_v[0]), .tx(tx_v[0]));
  uart_tx_frame #(.C_CLK_FRQ(100000000), .C_TRX_RATE(10000000), .C_PARITY(2), .C_STOP_BITS(1)) u_even (
    .clock(clock), .rstb(rstb_v[1]), .send(send_v[1]), .data(data_v[1]),
    .busy(busy_v[1]), .idle(idle_v[1]), .error(error_v[1]), .tx(tx_v[1]));
  uart_tx_frame #(.C_CLK_FRQ(100000000), .C_TRX_RATE(10000000), .C_PARITY(1), .C_STOP_BITS(1)) u_odd (
    .clock(clock), .rstb(rstb_v[2]), .send(send_v[2]), .data(data_v[2]),
    .busy(busy_v[2]), .idle(idle_v[2]), .error(error_v[2]), .tx(tx_v[2]));
  uart_tx_frame #(.C_CLK_FRQ(100000000), .C_TRX_RATE(10000000), .C_PARITY(0), .C_STOP_BITS(2)) u_stop2 (
    .clock(clock), .rstb(rstb_v[3]), .send(send_v[3]), .data(data_v[3]),
    .busy(busy_v[3]), .idle(idle_v[3]), .error(error_v[3]), .tx(tx_v[3]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int par_of(input int k);
    return (k == 1) ? 2 : ((k == 2) ? 1 : 0);
  endfunction

  function automatic int stop_of(input int k);
    return (k == 3) ? 2 : 1;
  endfunction

  function automatic int flen(input int k);
    return (9 + ((par_of(k) != 0) ? 1 : 0) + stop_of(k)) * P;
  endfunction

  task automatic prep();
    sl_q.delete(); sd_q.delete(); hs_q.delete();
    exp_tx.delete(); exp_b_q.delete();
    rst_slot = -1;
  endtask

  task automatic exp_idle(input int n);
    repeat (n) exp_tx.push_back(1'b1);
  endtask

  // Line model: each symbol of the frame held for P clocks; parity makes the total count of ones even/odd.
  task automatic exp_frame(input int k, input logic [7:0] b);
    int   ones;
    logic pb;
    ones = $countones(b);
    exp_b_q.push_back(b);
    repeat (P) exp_tx.push_back(1'b0);
    for (int j = 0; j < 8; j++) repeat (P) exp_tx.push_back(b[j]);
    if (par_of(k) != 0) begin
      pb = (par_of(k) == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
      repeat (P) exp_tx.push_back(pb);
    end
    repeat (stop_of(k) * P) exp_tx.push_back(1'b1);
  endtask

  // Sample outputs at each falling edge, then drive inputs for the following rising edge.
  task automatic run(input int k, input int ncyc);
    int gap = 0;
    rec_tx.delete(); rec_err.delete(); rec_busy.delete(); rec_idle.delete();
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clock);
      rec_tx.push_back(tx_v[k]);
      rec_err.push_back(error_v[k]);
      rec_busy.push_back(busy_v[k]);
      rec_idle.push_back(idle_v[k]);
      rstb_v[k] = (c == rst_slot) ? 1'b0 : 1'b1;
      send_v[k] = 1'b0;
      if (sl_q.size() > 0 && sl_q[0] == c) begin
        send_v[k] = 1'b1;
        data_v[k] = sd_q.pop_front();
        void'(sl_q.pop_front());
        $display("[%0t] dut%0d send 0x%02h (scheduled)", $time, k, data_v[k]);
      end else if (hs_q.size() > 0 && gap == 0 && busy_v[k] == 1'b0) begin
        send_v[k] = 1'b1;
        data_v[k] = hs_q.pop_front();
        gap = $urandom_range(0, 12);
        $display("[%0t] dut%0d send 0x%02h (random)", $time, k, data_v[k]);
      end else if (gap > 0) begin
        gap--;
      end
    end
    send_v[k] = 1'b0;
    rstb_v[k] = 1'b1;
  endtask

  function automatic int wave_diff();
    logic e;
    for (int i = 0; i < rec_tx.size(); i++) begin
      e = (i < exp_tx.size()) ? exp_tx[i] : 1'b1;
      if (rec_tx[i] !== e) return i;
    end
    return -1;
  endfunction

  // Receiver model: find a falling edge, sample every symbol at its centre.
  task automatic decode(input int k);
    int         i, nb, hp, ones, pbit;
    logic [7:0] b;
    dec_q.delete();
    ferr = 0;
    hp = (par_of(k) != 0) ? 1 : 0;
    nb = 9 + hp + stop_of(k);
    i  = 1;
    while (i + nb * P <= rec_tx.size()) begin
      if (rec_tx[i-1] === 1'b1 && rec_tx[i] === 1'b0) begin
        if (rec_tx[i + P/2] !== 1'b0) ferr++;
        for (int j = 0; j < 8; j++) b[j] = rec_tx[i + (j + 1) * P + P/2];
        ones = $countones(b);
        if (hp == 1) begin
          pbit = (rec_tx[i + 9 * P + P/2] === 1'b1) ? 1 : 0;
          if (par_of(k) == 2 && (ones + pbit) % 2 != 0) ferr++;
          if (par_of(k) == 1 && (ones + pbit) % 2 != 1) ferr++;
        end
        for (int s = 0; s < stop_of(k); s++)
          if (rec_tx[i + (9 + hp + s) * P + P/2] !== 1'b1) ferr++;
        dec_q.push_back(b);
        i += nb * P;
      end else begin
        i++;
      end
    end
  endtask

  function automatic int dec_diff();
    int d = 0;
    if (dec_q.size() != exp_b_q.size()) return 1000 + dec_q.size();
    for (int i = 0; i < dec_q.size(); i++) if (dec_q[i] !== exp_b_q[i]) d++;
    return d;
  endfunction

  task automatic test_reset();
    rstb_v = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      send_v[k] = 1'($urandom);
      data_v[k] = 8'($urandom);
    end
    repeat (2) @(negedge clock);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({tx_v[k], busy_v[k], idle_v[k], error_v[k]} !== 4'b1010)
        $display("FAIL reset dut%0d: tx/busy/idle/error=%b, required 1010", k,
                 {tx_v[k], busy_v[k], idle_v[k], error_v[k]});
      else n_pass++;
    end
    rstb_v = 4'b1111;
    send_v = 4'b0000;
    @(negedge clock);
  endtask

  task automatic test_single_frame(input int k, input logic [7:0] b);
    int L, d;
    prep();
    L = flen(k);
    sl_q.push_back(0); sd_q.push_back(b);
    exp_idle(2); exp_frame(k, b);
    run(k, L + 8);
    n_checks++;
    if ({rec_tx[1], rec_tx[2]} !== 2'b10)
      $display("FAIL latency dut%0d: tx after accept edge, next edge=%b, required 10", k, {rec_tx[1], rec_tx[2]});
    else n_pass++;
    n_checks++;
    if ({rec_busy[1], rec_busy[2]} !== 2'b10)
      $display("FAIL busy_load dut%0d: busy=%b, required 10", k, {rec_busy[1], rec_busy[2]});
    else n_pass++;
    d = wave_diff();
    n_checks++;
    if (d != -1)
      $display("FAIL wave dut%0d byte 0x%02h: tx=%b at cycle %0d, required %b", k, b, rec_tx[d], d, ~rec_tx[d]);
    else n_pass++;
    n_checks++;
    if ({rec_idle[L+1], rec_idle[L+2]} !== 2'b01)
      $display("FAIL idle_end dut%0d: idle=%b, required 01", k, {rec_idle[L+1], rec_idle[L+2]});
    else n_pass++;
    decode(k);
    n_checks++;
    if (dec_diff() != 0 || ferr != 0)
      $display("FAIL decode dut%0d: got %0d bytes first 0x%02h ferr %0d, required 0x%02h", k,
               dec_q.size(), (dec_q.size() > 0) ? dec_q[0] : 8'h00, ferr, b);
    else n_pass++;
  endtask

  task automatic test_stop2();
    logic [7:0] b2;
    int i = 2, lo = 0, hi = 0, d;
    prep();
    b2 = 8'($urandom);
    sl_q.push_back(0); sd_q.push_back(8'h00);
    sl_q.push_back(1); sd_q.push_back(b2);
    exp_idle(2); exp_frame(3, 8'h00); exp_frame(3, b2);
    run(3, 2 + 2 * flen(3) + 6);
    while (i < rec_tx.size() && rec_tx[i] === 1'b0) begin lo++; i++; end
    while (i < rec_tx.size() && rec_tx[i] === 1'b1) begin hi++; i++; end
    n_checks++;
    if (lo != 90 || hi != 20 || i != 112)
      $display("FAIL stop2_timing: low %0d high %0d next start %0d, required 90 20 112", lo, hi, i);
    else n_pass++;
    d = wave_diff();
    n_checks++;
    if (d != -1) $display("FAIL stop2_wave: tx=%b at cycle %0d, required %b", rec_tx[d], d, ~rec_tx[d]);
    else n_pass++;
    decode(3);
    n_checks++;
    if (dec_diff() != 0 || ferr != 0)
      $display("FAIL stop2_decode: %0d bytes ferr %0d, required 00 %02h", dec_q.size(), ferr, b2);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int d, nerr = 0, nidle = 0;
    prep();
    sl_q.push_back(0); sd_q.push_back(8'hA5);
    sl_q.push_back(1); sd_q.push_back(8'h3C);
    exp_idle(2); exp_frame(0, 8'hA5); exp_frame(0, 8'h3C);
    run(0, 208);
    n_checks++;
    if (rec_busy[2] !== 1'b1) $display("FAIL b2b_busy: busy=%b, required 1", rec_busy[2]);
    else n_pass++;
    n_checks++;
    if ({rec_tx[101], rec_tx[102]} !== 2'b10)
      $display("FAIL b2b_gap: tx at stop end/next start=%b, required 10", {rec_tx[101], rec_tx[102]});
    else n_pass++;
    for (int i = 0; i < rec_err.size(); i++) if (rec_err[i] === 1'b1) nerr++;
    for (int i = 1; i < 202; i++) if (rec_idle[i] !== 1'b0) nidle++;
    n_checks++;
    if (nerr != 0 || nidle != 0)
      $display("FAIL b2b_flags: error pulses %0d idle cycles %0d, required 0 0", nerr, nidle);
    else n_pass++;
    d = wave_diff();
    n_checks++;
    if (d != -1) $display("FAIL b2b_wave: tx=%b at cycle %0d, required %b", rec_tx[d], d, ~rec_tx[d]);
    else n_pass++;
    decode(0);
    n_checks++;
    if (dec_diff() != 0 || ferr != 0)
      $display("FAIL b2b_decode: %0d bytes ferr %0d, required a5 3c", dec_q.size(), ferr);
    else n_pass++;
  endtask

  task automatic test_overrun();
    int d, nerr = 0;
    prep();
    sl_q.push_back(0); sd_q.push_back(8'hA5);
    sl_q.push_back(1); sd_q.push_back(8'h3C);
    sl_q.push_back(5); sd_q.push_back(8'hFF);
    exp_idle(2); exp_frame(0, 8'hA5); exp_frame(0, 8'h3C);
    run(0, 208);
    for (int i = 0; i < rec_err.size(); i++) if (rec_err[i] === 1'b1) nerr++;
    n_checks++;
    if (nerr != 1 || rec_err[6] !== 1'b1)
      $display("FAIL overrun_error: pulses %0d, at cycle 6 %b, required 1 1", nerr, rec_err[6]);
    else n_pass++;
    n_checks++;
    if (rec_busy[6] !== 1'b1) $display("FAIL overrun_busy: busy=%b, required 1", rec_busy[6]);
    else n_pass++;
    d = wave_diff();
    n_checks++;
    if (d != -1) $display("FAIL overrun_wave: tx=%b at cycle %0d, required %b", rec_tx[d], d, ~rec_tx[d]);
    else n_pass++;
    decode(0);
    n_checks++;
    if (dec_diff() != 0 || ferr != 0)
      $display("FAIL overrun_decode: %0d bytes ferr %0d, required a5 3c", dec_q.size(), ferr);
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    int d;
    prep();
    sl_q.push_back(0); sd_q.push_back(8'hA5);
    sl_q.push_back(1); sd_q.push_back(8'h3C);
    rst_slot = 45;  // edge 45 lies inside data bit 3 (cycles 42..51)
    exp_idle(2); exp_frame(0, 8'hA5);
    while (exp_tx.size() > 46) void'(exp_tx.pop_back());
    run(0, 160);
    n_checks++;
    if (rec_busy[45] !== 1'b1) $display("FAIL midrst_queued: busy=%b, required 1", rec_busy[45]);
    else n_pass++;
    n_checks++;
    if ({rec_tx[46], rec_busy[46], rec_idle[46]} !== 3'b101)
      $display("FAIL midrst_state: tx/busy/idle=%b, required 101", {rec_tx[46], rec_busy[46], rec_idle[46]});
    else n_pass++;
    d = wave_diff();
    n_checks++;
    if (d != -1) $display("FAIL midrst_wave: tx=%b at cycle %0d, required %b", rec_tx[d], d, ~rec_tx[d]);
    else n_pass++;
    n_checks++;
    if (rec_idle[159] !== 1'b1) $display("FAIL midrst_idle: idle=%b, required 1", rec_idle[159]);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int k = 0; k < 4; k++) begin
      prep();
      for (int n = 0; n < 3; n++) begin
        b = 8'($urandom);
        hs_q.push_back(b);
        exp_b_q.push_back(b);
      end
      run(k, 450);
      decode(k);
      n_checks++;
      if (dec_diff() != 0)
        $display("FAIL random_decode dut%0d: got %0d bytes (diff %0d), required %0d", k, dec_q.size(), dec_diff(), 3);
      else n_pass++;
      n_checks++;
      if (ferr != 0) $display("FAIL random_framing dut%0d: framing errors %0d, required 0", k, ferr);
      else n_pass++;
      n_checks++;
      if (rec_idle[449] !== 1'b1) $display("FAIL random_idle dut%0d: idle=%b, required 1", k, rec_idle[449]);
      else n_pass++;
    end
  endtask

  initial begin
    rstb_v = 4'b0000;
    send_v = 4'b0000;
    for (int k = 0; k < 4; k++) data_v[k] = 8'h00;
    rst_slot = -1;
    test_reset();
    test_single_frame(0, 8'h55);
    test_single_frame(1, 8'h07);
    test_single_frame(2, 8'h07);
    test_stop2();
    test_back_to_back();
    test_overrun();
    test_reset_midframe();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
